// File: rtl/inc_rr_sched.sv
// inc_rr_sched: round-robin scheduler that shares one +STEP incrementer among
// NREQ valid/ready requesters. It returns one tagged result per grant.
// Optional feature: define INC_RR_SCHED_SAT_EN to saturate the result at
// all-ones instead of wrapping modulo 2^WIDTH.
module inc_rr_sched #(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id
);

  // STEP is truncated to the datapath width; STEP=0 gives a pass-through.
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_opnd;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [IDW-1:0]   r_res_id;

  logic             w_win_found;
  logic [IDW-1:0]   w_win_id;
  logic [WIDTH-1:0] w_win_data;
  logic [NREQ-1:0]  w_req_ready;
  logic [WIDTH-1:0] w_res;

  // Requester index k places after base, wrapping at NREQ.
  function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % NREQ);
  endfunction

  // Winner search: the first valid requester starting just after the last grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_win_found = 1'b0;
    w_win_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_win_found && req_valid[rot(r_ptr, k)]) begin
        w_win_found = 1'b1;
        w_win_id    = rot(r_ptr, k);
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_id == IDW'(i)) w_win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // A one-hot accept goes only to the winner, only in IDLE, and never while reset is held.
  always_comb begin
    w_req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_win_found) w_req_ready[w_win_id] = 1'b1;
  end

`ifdef INC_RR_SCHED_SAT_EN
  // The extra carry bit detects overflow, so the result clamps to all-ones.
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, r_opnd} + {1'b0, STEP_W};
  assign w_res = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
  // The carry out is dropped, so the result wraps modulo 2^WIDTH.
  assign w_res = r_opnd + STEP_W;
`endif

  // Scheduler FSM: IDLE grants and captures, CALC computes, HOLD presents the result until it is taken.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (!rst_n) begin
      // NOTE: every register, including the operand and result registers, is cleared. A reset mid-operation leaves nothing stale behind.
      r_state     <= S_IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_opnd      <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_opnd  <= w_win_data;
            r_id    <= w_win_id;
            r_ptr   <= w_win_id;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_res_data  <= w_res;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule
